// File: rtl/kbd_pkg.sv
// Shared scan-code constants, FSM state encoding and byte classification
// for the PS/2 keyboard-display path.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // Keyboard status/ack bytes that carry no key information.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hAA) ||
               (code == 8'hFE) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/kbd_scan_ctrl_if.sv
// Byte-receiver input and display-control outputs of the scan controller.
interface kbd_scan_ctrl_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       pre;
    logic       up;
    logic [7:0] my_data;
    logic       caps_on;
    logic [7:0] press_cnt;
    logic       err_stb;

    modport master (
        output rx_valid, rx_data,
        input  pre, up, my_data, caps_on, press_cnt, err_stb
    );

    modport slave (
        input  rx_valid, rx_data,
        output pre, up, my_data, caps_on, press_cnt, err_stb
    );

endinterface

// File: rtl/kbd_prefix_timer.sv
// Watchdog for prefix sequences: counts while a prefix is pending and
// flags expiry when its follower byte never arrives.
module kbd_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    // A byte arriving in the expiry cycle wins, so clear masks expire.
    assign expire = run && !clear && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Turns raw PS/2 scan-code bytes into key-held, shift-table select,
// current make code, caps-lock state and a press counter.
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    kbd_scan_ctrl_if.slave        bus
);

    kbd_state_t state_reg;
    logic       lshift_reg;
    logic       rshift_reg;
    logic       caps_held_reg;
    logic       caps_on_reg;
    logic       pre_reg;
    logic [7:0] my_data_reg;
    logic [7:0] press_cnt_reg;
    logic       err_stb_reg;
    logic       expire;

    logic [7:0] code;
    assign code = bus.rx_data;

    kbd_prefix_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_prefix_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.rx_valid),
        .run    (state_reg != ST_IDLE),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            lshift_reg    <= 1'b0;
            rshift_reg    <= 1'b0;
            caps_held_reg <= 1'b0;
            caps_on_reg   <= 1'b0;
            pre_reg       <= 1'b0;
            my_data_reg   <= 8'h00;
            press_cnt_reg <= 8'h00;
            err_stb_reg   <= 1'b0;
        end else begin
            err_stb_reg <= 1'b0;
            if (bus.rx_valid) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (code == SC_BREAK) begin
                            state_reg <= ST_BRK;
                        end else if (code == SC_EXT) begin
                            state_reg <= ST_EXT;
                        end else if (is_ignored(code)) begin
                            state_reg <= ST_IDLE;
                        end else if (code == SC_LSHIFT) begin
                            lshift_reg <= 1'b1;
                        end else if (code == SC_RSHIFT) begin
                            rshift_reg <= 1'b1;
                        end else if (code == SC_CAPS) begin
                            // Only the first make of a held caps key toggles.
                            if (!caps_held_reg) begin
                                caps_on_reg <= ~caps_on_reg;
                            end
                            caps_held_reg <= 1'b1;
                        end else if (!(pre_reg && (code == my_data_reg))) begin
                            my_data_reg   <= code;
                            pre_reg       <= 1'b1;
                            press_cnt_reg <= press_cnt_reg + 8'd1;
                        end
                    end
                    ST_BRK: begin
                        state_reg <= ST_IDLE;
                        if (code == SC_LSHIFT) begin
                            lshift_reg <= 1'b0;
                        end else if (code == SC_RSHIFT) begin
                            rshift_reg <= 1'b0;
                        end else if (code == SC_CAPS) begin
                            caps_held_reg <= 1'b0;
                        end
                        if (code == my_data_reg) begin
                            pre_reg <= 1'b0;
                        end
                    end
                    ST_EXT: begin
                        state_reg <= (code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end else if (expire) begin
                state_reg   <= ST_IDLE;
                err_stb_reg <= 1'b1;
            end
        end
    end

    assign bus.pre       = pre_reg;
    assign bus.up        = (lshift_reg | rshift_reg) ^ caps_on_reg;
    assign bus.my_data   = my_data_reg;
    assign bus.caps_on   = caps_on_reg;
    assign bus.press_cnt = press_cnt_reg;
    assign bus.err_stb   = err_stb_reg;

endmodule
